// File: rtl/pong_input_cond_if.sv
// ============================================================================
//  Module      : pong_input_cond_if
//  Description : Bundle of raw user-input levels and their conditioned
//                counterparts exchanged with pong_input_cond.
//                master : input source side (drives raw levels/coordinates)
//                slave  : the conditioner (drives pulses and clamped coords)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pong_input_cond_if;
    // Raw side
    logic        button_raw;
    logic        mouse_left_raw;
    logic [11:0] xpos_raw;
    logic [11:0] ypos_raw;
    // Conditioned side
    logic        button;
    logic        mouse_left;
    logic        mouse_left_level;
    logic [11:0] xpos;
    logic [11:0] ypos;

    modport master (
        output button_raw,
        output mouse_left_raw,
        output xpos_raw,
        output ypos_raw,
        input  button,
        input  mouse_left,
        input  mouse_left_level,
        input  xpos,
        input  ypos
    );

    modport slave (
        input  button_raw,
        input  mouse_left_raw,
        input  xpos_raw,
        input  ypos_raw,
        output button,
        output mouse_left,
        output mouse_left_level,
        output xpos,
        output ypos
    );
endinterface

`default_nettype wire

// File: rtl/pong_input_cond.sv
// ============================================================================
//  Module      : pong_input_cond
//  Description : Conditions raw user inputs for the menu/game controller.
//                - push button: 2-flop sync, 4-state debounce, press pulse
//                - mouse left : 2-flop sync, rising-edge click pulse, level
//                - mouse x/y  : clamp to the visible area, delayed so the
//                               coordinates line up with the click pulse
//                Optional macro CLICK_HOLDOFF_EN adds a click hold-off
//                window that suppresses re-clicks for HOLDOFF_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_input_cond #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int H_MAX           = 1023,
    parameter int V_MAX           = 767,
    parameter int HOLDOFF_CYCLES  = 3250000
) (
    input  wire logic           clk,
    input  wire logic           rst,     // synchronous, active-low
    pong_input_cond_if.slave    bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0] c_H_MAX = 12'(H_MAX);
    localparam logic [11:0] c_V_MAX = 12'(V_MAX);

    // Debounce FSM encoding
    localparam logic [1:0] c_RELEASED  = 2'd0;
    localparam logic [1:0] c_ARMING    = 2'd1;
    localparam logic [1:0] c_PRESSED   = 2'd2;
    localparam logic [1:0] c_DISARMING = 2'd3;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic               r_btn_meta;
    logic               r_btn_s;
    logic               r_ml_meta;
    logic               r_ml_s;
    logic               r_ml_s_d;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               r_button;

    logic               w_hold_ok;
    logic               w_ml_rise;
    logic               r_mouse_left;

    logic [11:0]        w_x_clamp;
    logic [11:0]        w_y_clamp;
    logic [11:0]        r_x0;
    logic [11:0]        r_x1;
    logic [11:0]        r_x2;
    logic [11:0]        r_y0;
    logic [11:0]        r_y1;
    logic [11:0]        r_y2;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for both asynchronous button levels, plus
    // the one-cycle delayed mouse level used for edge detection.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_ml_meta  <= 1'b0;
            r_ml_s     <= 1'b0;
            r_ml_s_d   <= 1'b0;
        end else begin
            r_btn_meta <= bus.button_raw;
            r_btn_s    <= r_btn_meta;
            r_ml_meta  <= bus.mouse_left_raw;
            r_ml_s     <= r_ml_meta;
            r_ml_s_d   <= r_ml_s;
        end
    end

    // ------------------------------------------------------------------
    // Button debounce. The level must stay stable while the counter runs
    // up to DEBOUNCE_CYCLES-1; the transition fires on the edge where the
    // incremented count hits that value, so a clean press emerges exactly
    // 2 + DEBOUNCE_CYCLES cycles after the raw edge.
    // ------------------------------------------------------------------
    assign w_cnt_inc = r_cnt + 1'b1;

    // Debounce state machine and press pulse generation
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_RELEASED;
            r_cnt    <= '0;
            r_button <= 1'b0;
        end else begin
            r_button <= 1'b0;
            case (r_state)
                c_RELEASED: begin
                    if (r_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= c_ARMING;
                    end
                end
                c_ARMING: begin
                    if (!r_btn_s) begin
                        r_state <= c_RELEASED;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_CNT_LAST) begin
                            r_state  <= c_PRESSED;
                            r_button <= 1'b1;
                        end
                    end
                end
                c_PRESSED: begin
                    if (!r_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= c_DISARMING;
                    end
                end
                c_DISARMING: begin
                    if (r_btn_s) begin
                        r_state <= c_PRESSED;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Release is silent: no pulse on this transition
                        if (w_cnt_inc == c_CNT_LAST) begin
                            r_state <= c_RELEASED;
                        end
                    end
                end
                default: begin
                    r_state <= c_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional click hold-off. When enabled, a rising edge is only turned
    // into a click while the hold-off counter is idle at zero.
    // ------------------------------------------------------------------
`ifdef CLICK_HOLDOFF_EN
    localparam int c_HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLDOFF_CYCLES - 1);

    logic [c_HOLD_W-1:0] r_hold;

    assign w_hold_ok = (r_hold == '0);

    // Reload on every emitted click, then count down to zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (w_ml_rise) begin
            r_hold <= c_HOLD_LOAD;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end
    end
`else
    assign w_hold_ok = 1'b1;

    // Hold-off length has no effect in this build; keep it referenced
    if (HOLDOFF_CYCLES < 1) begin : g_holdoff_unused
    end
`endif

    assign w_ml_rise = r_ml_s & ~r_ml_s_d & w_hold_ok;

    // Registered click pulse: one cycle per accepted rising edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mouse_left <= 1'b0;
        end else begin
            r_mouse_left <= w_ml_rise;
        end
    end

    // ------------------------------------------------------------------
    // Coordinates: clamp on capture, then two more stages so that the
    // values seen with the click pulse are the ones sampled on the same
    // edge as the raw button edge (3 cycles, same as the click path).
    // ------------------------------------------------------------------
    assign w_x_clamp = (bus.xpos_raw > c_H_MAX) ? c_H_MAX : bus.xpos_raw;
    assign w_y_clamp = (bus.ypos_raw > c_V_MAX) ? c_V_MAX : bus.ypos_raw;

    // Clamp-and-align pipeline for x and y
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x0 <= '0;
            r_x1 <= '0;
            r_x2 <= '0;
            r_y0 <= '0;
            r_y1 <= '0;
            r_y2 <= '0;
        end else begin
            r_x0 <= w_x_clamp;
            r_x1 <= r_x0;
            r_x2 <= r_x1;
            r_y0 <= w_y_clamp;
            r_y1 <= r_y0;
            r_y2 <= r_y1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.button           = r_button;
    assign bus.mouse_left       = r_mouse_left;
    assign bus.mouse_left_level = r_ml_s_d;
    assign bus.xpos             = r_x2;
    assign bus.ypos             = r_y2;

endmodule

`default_nettype wire

// File: doc/pong_input_cond.md
Name: pong_input_cond

Overview:
- Conditions raw user inputs before they reach the top-level menu/game controller.
- Button path: synchronises and debounces the push button, then emits a single-cycle press pulse.
- Mouse path: synchronises the mouse left button, emits a single-cycle click pulse, and clamps mouse coordinates to the 1024x768 visible area.
- A one-cycle click lets the downstream menu toggle the difficulty exactly once per click, not once per clock while the button is held.

Parameters:
- DEBOUNCE_CYCLES, 650000: cycles a raw button level must stay stable before it is accepted (10 ms at 65 MHz).
- H_MAX, 1023: largest legal x coordinate; xpos is clamped to this.
- V_MAX, 767: largest legal y coordinate; ypos is clamped to this.
- HOLDOFF_CYCLES, 3250000: click hold-off length (50 ms). Used only with CLICK_HOLDOFF_EN.

Ports:
- clk  in  1  pixel clock (65 MHz).
- rst  in  1  synchronous reset, active-low.
- button_raw  in  1  asynchronous push-button level, 1 = pressed.
- mouse_left_raw  in  1  mouse left-button level from the mouse interface, 1 = pressed.
- xpos_raw  in  12  mouse x from the mouse interface.
- ypos_raw  in  12  mouse y from the mouse interface.
- button  out  1  single-cycle pulse on each debounced press.
- mouse_left  out  1  single-cycle pulse on each left-button press.
- mouse_left_level  out  1  synchronised left-button level.
- xpos  out  12  clamped x; captured every cycle.
- ypos  out  12  clamped y; captured every cycle.

Behaviour:
- Reset (rst == 0 at a clk edge) clears all outputs to 0, both synchronisers to 0, the debounce counter to 0, and puts the FSM in RELEASED. Reset mid-debounce discards partial counts.
- Synchronisers: button_raw and mouse_left_raw each pass through a 2-flop synchroniser. The synchronised signals are btn_s and ml_s.
- Debounce FSM, four states:
  - RELEASED: if btn_s == 1, clear the counter and go to ARMING.
  - ARMING: if btn_s == 0, return to RELEASED. Otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES-1, go to PRESSED and assert button for exactly one cycle on that transition.
  - PRESSED: if btn_s == 0, clear the counter and go to DISARMING.
  - DISARMING: if btn_s == 1, return to PRESSED. Otherwise increment; at DEBOUNCE_CYCLES-1 go to RELEASED. No pulse on release.
- Counter width is $clog2(DEBOUNCE_CYCLES). A glitch shorter than DEBOUNCE_CYCLES never produces a pulse.
- Button latency: a clean press produces its pulse exactly 2 + DEBOUNCE_CYCLES cycles after the raw rising edge.
- Mouse click: mouse_left = ml_s & ~ml_s_d (ml_s_d is ml_s delayed one cycle), registered.
  - Latency: 3 cycles from the raw rising edge.
  - One pulse per press, regardless of hold duration. No debounce on the mouse path; the mouse interface is already clean.
  - mouse_left_level = ml_s_d.
- Coordinates: xpos <= (xpos_raw > H_MAX) ? H_MAX : xpos_raw, registered. ypos follows the same rule against V_MAX. Latency is 1 cycle.
- Coordinate/click alignment: xpos and ypos are delayed by 2 extra cycles so that the values presented in the cycle mouse_left is high are the raw coordinates sampled together with the raw edge. Total coordinate latency is 3 cycles, matching the click.
- Simultaneous events: the button and mouse paths are independent. Both pulses may be high in the same cycle; the downstream controller resolves priority.

Optional Feature:
- Macro: CLICK_HOLDOFF_EN.
- Defined: after each mouse_left pulse, a hold-off counter loads HOLDOFF_CYCLES-1 and counts down to 0.
  - Rising edges of ml_s seen while the counter is non-zero are suppressed: no pulse is produced.
  - mouse_left_level is unaffected.
  - Reset clears the hold-off counter.
- Undefined: no hold-off counter is built; every rising edge pulses.

Test Plan:
1. Reset held low for 5 cycles with inputs toggling -> button, mouse_left, xpos and ypos all 0 throughout. First post-reset press behaves normally.
2. Bench DEBOUNCE_CYCLES=16. button_raw high for 40 cycles -> exactly one button pulse, 18 cycles after the edge. Release for 40 cycles -> no pulse.
3. DEBOUNCE_CYCLES=16. button_raw glitches high for 10 cycles, then low -> no button pulse, FSM back in RELEASED.
4. mouse_left_raw held high for 100 cycles with xpos_raw=500, ypos_raw=100 -> one mouse_left pulse 3 cycles after the edge, with xpos=500 and ypos=100 in that cycle. mouse_left_level high throughout the hold.
5. xpos_raw=2000, ypos_raw=4095 -> xpos=1023, ypos=767. xpos_raw=0 -> xpos=0.
6. With CLICK_HOLDOFF_EN, HOLDOFF_CYCLES=50: two clicks 20 cycles apart -> one pulse. Two clicks 60 cycles apart -> two pulses. Without the macro, both spacings -> two pulses.
